// File: rtl/bsc_encoder.sv
// bsc_encoder
//   Backscatter line encoder for the tag reply path. Builds one complete reply
//   frame: an optional pilot, the preamble, a streamed payload of up to
//   2^LEN_W-1 bits and the dummy-1 terminator. The frame is FM0-coded or
//   Miller-coded with M=2/4/8. Payload bits are pulled one symbol at a time
//   from an external shift register through bit_rd/bit_in.
//   One DOUB_BLF cycle is one half-BLF period.
//
// Ports
//   DOUB_BLF  in   clock (2x BLF)
//   rst_n     in   synchronous active-low reset
//   start     in   1-cycle frame request, accepted in IDLE or DONE
//   abort     in   kill the frame in progress (wins over start)
//   m_value   in   00 FM0, 01 M2, 10 M4, 11 M8 (latched at start)
//   trext     in   pilot enable (latched at start)
//   bit_len   in   payload bit count (latched at start)
//   bit_in    in   current payload bit, valid while bit_rd=1
//   bit_rd    out  1-cycle pulse in the first cycle of each payload symbol
//   tag_data  out  encoded backscatter level
//   busy      out  frame in progress
//   done      out  1-cycle pulse after the last dummy-1 cycle
module bsc_encoder #(
  parameter int LEN_W     = 12,
  parameter int PILOT_FM0 = 12,
  parameter int PILOT_MS  = 4,
  parameter int PILOT_ML  = 16
) (
  input  logic             DOUB_BLF,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       m_value,
  input  logic             trext,
  input  logic [LEN_W-1:0] bit_len,
  input  logic             bit_in,
  output logic             bit_rd,
  output logic             tag_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PILOT,
    S_PRE,
    S_DATA,
    S_DUMMY,
    S_DONE
  } state_t;

  // FM0 preamble half-bits 110100100011, stored LSB = first half-bit.
  localparam logic [11:0] FM0_PRE = 12'b110001001011;
  // Miller preamble symbols 010111, stored LSB = first symbol.
  localparam logic [5:0]  MIL_PRE = 6'b111010;

  state_t           r_state;
  logic [LEN_W-1:0] r_sym;       // symbol index within the current phase
  logic [3:0]       r_half;      // cycle index within the current symbol
  logic [3:0]       r_half_max;  // symbol length - 1 (FM0 1, Miller 2M-1)
  logic [LEN_W-1:0] r_pilot_m1;  // pilot symbol count - 1
  logic [LEN_W-1:0] r_len;
  logic             r_miller;
  logic             r_fm0;       // FM0 level of the current cycle
  logic             r_sc;        // Miller subcarrier phase
  logic             r_b;         // Miller baseband before any start-of-symbol flip
  logic             r_prev;      // previous coded Miller symbol
  logic             r_cur_bit;   // bit of the current symbol, held after cycle 0
  logic             r_busy;
  logic             r_bit_rd;
  logic             r_done;

  state_t           w_state_n;
  logic [LEN_W-1:0] w_sym_n;
  logic [3:0]       w_half_n;
  logic             w_launch;
  logic             w_last_half;
  logic             w_sym_bit;
  logic             w_coded;
  logic             w_inv_start;
  logic             w_inv_mid;
  logic             w_b;
  logic             w_fm0_n;
  logic             w_busy_n;

  assign w_last_half = (r_half == r_half_max);
  // Pilot symbols are excluded from the Miller inversion rules.
  assign w_coded = (r_state == S_PRE) || (r_state == S_DATA) || (r_state == S_DUMMY);

  // Bit carried by the current symbol. A payload bit is only present on
  // bit_in during its first cycle, so it is held in r_cur_bit afterwards.
  always_comb begin
    w_sym_bit = 1'b0;
    case (r_state)
      S_PRE:   w_sym_bit = MIL_PRE[r_sym[2:0]];
      S_DATA:  w_sym_bit = (r_half == 4'd0) ? bit_in : r_cur_bit;
      S_DUMMY: w_sym_bit = 1'b1;
      default: w_sym_bit = 1'b0;
    endcase
  end

  // A data-0 after a data-0 flips b at the symbol boundary. For payload
  // symbols the bit only arrives in that same cycle, so the flip is applied
  // combinationally on top of r_b and folded into r_b at the next edge.
  assign w_inv_start = w_coded && (r_half == 4'd0) && !w_sym_bit && !r_prev;
  assign w_b         = r_b ^ w_inv_start;
  // A data-1 flips b after M cycles; (2M-1)>>1 is M-1, the cycle before.
  assign w_inv_mid   = w_coded && w_sym_bit && (r_half == (r_half_max >> 1));

  // Position (state, symbol, half) of the next cycle.
  always_comb begin
    w_state_n = r_state;
    w_sym_n   = r_sym;
    w_half_n  = r_half + 4'd1;
    w_launch  = 1'b0;
    if (r_state == S_IDLE) begin
      w_sym_n  = '0;
      w_half_n = '0;
      w_launch = start;
    end else if (r_state == S_DONE) begin
      w_state_n = S_IDLE;
      w_sym_n   = '0;
      w_half_n  = '0;
      w_launch  = start;
    end else if (w_last_half) begin
      w_half_n = '0;
      w_sym_n  = r_sym + LEN_W'(1);
      if (r_state == S_PILOT) begin
        if (r_sym == r_pilot_m1) begin
          w_state_n = S_PRE;
          w_sym_n   = '0;
        end
      end else if (r_state == S_PRE) begin
        if (r_sym == LEN_W'(5)) begin
          w_state_n = (r_len != '0) ? S_DATA : S_DUMMY;
          w_sym_n   = '0;
        end
      end else if (r_state == S_DATA) begin
        if (r_sym == r_len - LEN_W'(1)) begin
          w_state_n = S_DUMMY;
          w_sym_n   = '0;
        end
      end else begin
        w_state_n = S_DONE;
        w_sym_n   = '0;
      end
    end
    if (w_launch) begin
      w_state_n = (trext || (m_value != 2'b00)) ? S_PILOT : S_PRE;
      w_sym_n   = '0;
      w_half_n  = '0;
    end
    if (abort) begin
      w_state_n = S_IDLE;
      w_sym_n   = '0;
      w_half_n  = '0;
      w_launch  = 1'b0;
    end
  end

  // FM0 level of the next cycle. Pilot and preamble are fixed patterns; data
  // and dummy invert at every boundary, and data-0 also inverts mid-symbol.
  always_comb begin
    w_fm0_n = 1'b0;
    case (w_state_n)
      S_PILOT: w_fm0_n = (w_half_n == 4'd0);
      S_PRE:   w_fm0_n = FM0_PRE[{w_sym_n[2:0], w_half_n[0]}];
      S_DATA,
      S_DUMMY: w_fm0_n = (w_half_n == 4'd0) ? ~r_fm0 : (w_sym_bit ? r_fm0 : ~r_fm0);
      default: w_fm0_n = 1'b0;
    endcase
  end

  assign w_busy_n = (w_state_n == S_PILOT) || (w_state_n == S_PRE) ||
                    (w_state_n == S_DATA)  || (w_state_n == S_DUMMY);

  always_ff @(posedge DOUB_BLF) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sym      <= '0;
      r_half     <= '0;
      r_half_max <= '0;
      r_pilot_m1 <= '0;
      r_len      <= '0;
      r_miller   <= 1'b0;
      r_fm0      <= 1'b0;
      r_sc       <= 1'b0;
      r_b        <= 1'b0;
      r_prev     <= 1'b0;
      r_cur_bit  <= 1'b0;
      r_busy     <= 1'b0;
      r_bit_rd   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_sym     <= w_sym_n;
      r_half    <= w_half_n;
      r_busy    <= w_busy_n;
      r_bit_rd  <= (w_state_n == S_DATA) && (w_half_n == 4'd0);
      r_done    <= (w_state_n == S_DONE);
      r_fm0     <= w_fm0_n;
      r_sc      <= ~r_sc;
      r_b       <= w_b ^ w_inv_mid;
      r_cur_bit <= w_sym_bit;
      if (w_coded && w_last_half) begin
        r_prev <= w_sym_bit;
      end
      if (w_launch) begin
        r_len    <= bit_len;
        r_miller <= (m_value != 2'b00);
        r_sc     <= 1'b1;
        r_b      <= 1'b0;
        // The preamble's leading 0 must not invert, so the history starts at 1.
        r_prev   <= 1'b1;
        case (m_value)
          2'b00:   r_half_max <= 4'd1;
          2'b01:   r_half_max <= 4'd3;
          2'b10:   r_half_max <= 4'd7;
          default: r_half_max <= 4'd15;
        endcase
        if (m_value == 2'b00) begin
          r_pilot_m1 <= LEN_W'(PILOT_FM0 - 1);
        end else if (trext) begin
          r_pilot_m1 <= LEN_W'(PILOT_ML - 1);
        end else begin
          r_pilot_m1 <= LEN_W'(PILOT_MS - 1);
        end
      end
    end
  end

  assign bit_rd   = r_bit_rd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tag_data = r_busy && (r_miller ? (w_b ^ r_sc) : r_fm0);

endmodule

// File: tb/tb_bsc_encoder.sv
// tb_bsc_encoder
//   Directed bench for bsc_encoder: reset, FM0 frames with and without pilot,
//   Miller M=2/4/8 frames, abort, reset mid-frame, start/config changes while
//   busy and back-to-back frames started in the DONE cycle.
module tb_bsc_encoder;
  localparam int LEN_W = 12;

  logic             DOUB_BLF = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [1:0]       m_value;
  logic             trext;
  logic [LEN_W-1:0] bit_len;
  logic             bit_in;
  logic             bit_rd;
  logic             tag_data;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  bit src [0:4095];
  int ptr = 0;
  bit exp_tag_q[$];
  bit exp_rd_q[$];

  bsc_encoder #(.LEN_W(LEN_W)) dut (
    .DOUB_BLF (DOUB_BLF),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .m_value  (m_value),
    .trext    (trext),
    .bit_len  (bit_len),
    .bit_in   (bit_in),
    .bit_rd   (bit_rd),
    .tag_data (tag_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 DOUB_BLF = ~DOUB_BLF;

  // One clock cycle. Pulse inputs are cleared, the bit source presents the
  // next bit whenever bit_rd is high, and outputs are sampled at the negedge.
  task automatic tick();
    @(posedge DOUB_BLF);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (bit_rd) begin
      bit_in = (ptr < 4096) ? src[ptr] : 1'b0;
      ptr++;
    end else begin
      bit_in = 1'b0;
    end
    @(negedge DOUB_BLF);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic kick(input logic [1:0] m, input logic t, input int len);
    m_value = m;
    trext   = t;
    bit_len = LEN_W'(len);
    start   = 1'b1;
    ptr     = 0;
  endtask

  task automatic load_hand(input string t, input int rd_first, input int rd_step, input int rd_n);
    exp_tag_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < t.len(); i++) begin
      exp_tag_q.push_back(t[i] == 8'h31);
      exp_rd_q.push_back(1'b0);
    end
    for (int k = 0; k < rd_n; k++) begin
      exp_rd_q[rd_first - 1 + k * rd_step] = 1'b1;
    end
  endtask

  // Symbol-level Miller reference: each symbol is 2M cycles of b XOR sc,
  // sc=1 in cycle 1 of the frame and alternating thereafter.
  task automatic build_miller(input int msel, input bit t, input int len);
    bit pre [0:5];
    int mm;
    int npil;
    int cyc;
    bit b;
    bit prev;
    bit v;
    bit pil;
    bit dat;
    pre  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    mm   = 1 << msel;
    npil = t ? 16 : 4;
    cyc  = 0;
    b    = 1'b0;
    prev = 1'b1;
    exp_tag_q.delete();
    exp_rd_q.delete();
    for (int s = 0; s < npil + 6 + len + 1; s++) begin
      pil = (s < npil);
      dat = (s >= npil + 6) && (s < npil + 6 + len);
      if (pil)                v = 1'b0;
      else if (s < npil + 6)  v = pre[s - npil];
      else if (dat)           v = src[s - npil - 6];
      else                    v = 1'b1;
      if (!pil && !v && !prev) b = ~b;
      for (int h = 0; h < 2 * mm; h++) begin
        if (!pil && v && h == mm) b = ~b;
        cyc++;
        exp_tag_q.push_back(b ^ cyc[0]);
        exp_rd_q.push_back(dat && (h == 0));
      end
      if (!pil) prev = v;
    end
  endtask

  // Runs one frame against the expectation queues. At cycle inj (if nonzero)
  // a stray start and new configuration are applied mid-frame.
  task automatic check_frame(input string name, input int inj);
    int n_tag;
    int n_rd;
    int n_st;
    int first;
    int n_exp_rd;
    n_tag = 0; n_rd = 0; n_st = 0; first = 0; n_exp_rd = 0;
    for (int i = 0; i < exp_tag_q.size(); i++) begin
      tick();
      if (tag_data !== exp_tag_q[i]) begin
        n_tag++;
        if (first == 0) first = i + 1;
      end
      if (bit_rd !== exp_rd_q[i]) n_rd++;
      if (exp_rd_q[i]) n_exp_rd++;
      if (busy !== 1'b1 || done !== 1'b0) n_st++;
      if (i + 1 == inj) begin
        start   = 1'b1;
        m_value = ~m_value;
        trext   = ~trext;
        bit_len = LEN_W'(7);
      end
    end
    chk($sformatf("%s.tag_err_cycles(first@%0d)", name, first), n_tag, 0);
    chk({name, ".bit_rd_err_cycles"}, n_rd, 0);
    chk({name, ".busy_done_err_cycles"}, n_st, 0);
    chk({name, ".bits_consumed"}, ptr, n_exp_rd);
  endtask

  task automatic check_done(input string name);
    tick();
    chk({name, ".done"}, done, 1);
    chk({name, ".busy_in_done"}, busy, 0);
    chk({name, ".tag_in_done"}, tag_data, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_value = 2'b00;
    trext = 1'b0; bit_len = '0; bit_in = 1'b0;
    repeat (3) tick();
    chk("rst.tag", tag_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.bit_rd", bit_rd, 0);
    chk("rst.done", done, 0);
    rst_n = 1'b1;
    tick();

    // abort in IDLE, then abort together with start
    abort = 1'b1;
    tick();
    chk("idle_abort.busy", busy, 0);
    kick(2'b00, 1'b0, 2);
    abort = 1'b1;
    tick();
    chk("abort_start.outs", {tag_data, busy, bit_rd, done}, 0);
    tick();
    chk("abort_start.busy_later", busy, 0);

    // case 1: FM0, no pilot, bits 1,0
    src[0] = 1'b1; src[1] = 1'b0;
    kick(2'b00, 1'b0, 2);
    load_hand("110100100011001011", 13, 2, 2);
    check_frame("c1", 0);
    check_done("c1");

    // case 2: FM0 with pilot, empty payload, started in the DONE cycle
    kick(2'b00, 1'b1, 0);
    load_hand({"101010101010101010101010", "110100100011", "00"}, 0, 0, 0);
    check_frame("c2", 0);
    check_done("c2");
    tick();
    chk("c2.done_one_cycle", done, 0);

    // case 3: Miller M=2, short pilot, single data-1
    src[0] = 1'b1;
    kick(2'b01, 1'b0, 1);
    load_hand({"1010101010101010", "1010", "1001", "0101", "0110",
               "1001", "0110", "1001", "0110"}, 41, 4, 1);
    check_frame("c3", 0);
    check_done("c3");

    // Miller M=4 with consecutive data-0 symbols
    src[0] = 1'b0; src[1] = 1'b0; src[2] = 1'b1; src[3] = 1'b0; src[4] = 1'b0;
    kick(2'b10, 1'b0, 5);
    build_miller(2, 1'b0, 5);
    check_frame("m4", 0);
    check_done("m4");

    // case 4: Miller M=8, long pilot, maximum-length random payload
    for (int i = 0; i < 4095; i++) src[i] = 1'($urandom_range(0, 1));
    kick(2'b11, 1'b1, 4095);
    build_miller(3, 1'b1, 4095);
    check_frame("c4", 0);
    check_done("c4");

    // case 5: abort at cycle 14, restart at cycle 16
    tick();
    src[0] = 1'b1; src[1] = 1'b0;
    kick(2'b00, 1'b0, 2);
    repeat (14) tick();
    abort = 1'b1;
    tick();
    chk("c5.after_abort", {tag_data, busy, bit_rd, done}, 0);
    tick();
    chk("c5.idle16", {busy, done}, 0);
    kick(2'b00, 1'b0, 2);
    load_hand("110100100011001011", 13, 2, 2);
    check_frame("c5", 0);
    check_done("c5");

    // case 6: start and configuration changes while busy leave the frame intact
    kick(2'b00, 1'b0, 2);
    load_hand("110100100011001011", 13, 2, 2);
    check_frame("c6_busy_start", 5);
    check_done("c6_busy_start");

    // case 6: reset in the middle of DATA
    tick();
    kick(2'b00, 1'b0, 2);
    repeat (13) tick();
    chk("c6.bit_rd_at13", bit_rd, 1);
    rst_n = 1'b0;
    tick();
    chk("c6.reset_outs", {tag_data, busy, bit_rd, done}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("c6.idle_after_reset", {busy, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
